decoder3to8_seq: RTL

//  Sequential 3-to-8 decoder. It is the receive-side counterpart of the 8-to-3 priority encoder.
//  - Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
//  - Replays each code as a one-hot 8-bit pattern held for HOLD_CYCLES cycles.
//  - Each pattern is followed by one all-zero gap cycle.
//  - Sits between the encoder path and downstream one-hot consumers (line enables, LED/strobe banks).

---
 rtl/decoder3to8_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/decoder3to8_seq.sv
// Sequential 3-to-8 decoder with an input code FIFO.
// Each code is replayed as a held one-hot pattern followed by a zero gap.
module decoder3to8_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_code,
  input  logic                        flush,
  output logic [7:0]                  out,
  output logic                        out_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL =
    (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] HOLD_M1 =
    8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    out_d;
  logic          vld_d;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          can_pop;
  logic          push;
  logic          pop;

  assign in_ready   = (cnt_q != FULL);
  assign fifo_count = cnt_q;
  assign can_pop    = (state_q != DRIVE);
  assign push = in_valid && in_ready
             && !flush;
  assign pop  = can_pop && (cnt_q != '0)
             && !flush;

  // Code storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= in_code;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case (1'b1)
        push && !pop: cnt_q <= cnt_q + 1'b1;
        pop && !push: cnt_q <= cnt_q - 1'b1;
        default:      cnt_q <= cnt_q;
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      out       <= out_d;
      out_valid <= vld_d;
    end
  end

  // Next state: pop into DRIVE, count down, then gap.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    out_d   = out;
    vld_d   = out_valid;
    unique case (state_q)
      IDLE, GAP: begin
        if (pop) begin
          out_d   = 8'h01 << mem[rptr_q];
          vld_d   = 1'b1;
          hold_d  = HOLD_M1;
          state_d = DRIVE;
        end else begin
          out_d   = '0;
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      DRIVE: begin
        if (hold_q == '0) begin
          out_d   = '0;
          vld_d   = 1'b0;
          state_d = GAP;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: begin
        out_d   = '0;
        vld_d   = 1'b0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      out_d   = '0;
      vld_d   = 1'b0;
      hold_d  = '0;
      state_d = IDLE;
    end
  end

endmodule
